bank_spi_loader: RTL and testbench

SPI-slave loader that fills a feature-map memory bank through the bank's write port (port B). It deserializes MSB-first bytes from the external host, generates sequential write addresses from 0 upward, and pulses the write strobe once per byte. This block provides the synthesizable load path into the bank. One instance sits beside each bank; the load is triggered by a start pulse from the accelerator controller.

---
 rtl/bank_spi_loader.sv | 157 +++++++++++++++
 tb/tb_bank_spi_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_spi_loader.sv
// SPI-slave (mode 0) loader that writes MSB-first bytes into a bank's port B at addresses 0, 1, 2, ...
// Optional feature macro: LOADER_CHECKSUM_EN adds a modulo-2^DATA_WIDTH sum of the written words.
module bank_spi_loader #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] data_b,
    output logic                  wrenb,
    output logic                  csen,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_cnt
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0] WORD_LAST = (ADDR_WIDTH + 1)'(DATA_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, ARMED, SHIFT, WRITE, DONE} state_t;

    state_t state, state_nx;

    logic sclk_p0, sclk_p1, sclk_p2, sclk_rise_p3;
    logic cs_p0, cs_p1, cs_p2, cs_rise_p3;
    logic mosi_p0, mosi_p1, mosi_p2;

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  full;

    // Synchronizers (p0/p1), edge history (p2) and registered edge pulses (p3).
    // mosi_p2 lines up with the sclk edge that sclk_rise_p3 reports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_p0      <= 1'b0;
            sclk_p1      <= 1'b0;
            sclk_p2      <= 1'b0;
            sclk_rise_p3 <= 1'b0;
            cs_p0        <= 1'b1;
            cs_p1        <= 1'b1;
            cs_p2        <= 1'b1;
            cs_rise_p3   <= 1'b0;
            mosi_p0      <= 1'b0;
            mosi_p1      <= 1'b0;
            mosi_p2      <= 1'b0;
        end else begin
            sclk_p0      <= spi_sclk;
            sclk_p1      <= sclk_p0;
            sclk_p2      <= sclk_p1;
            sclk_rise_p3 <= sclk_p1 & ~sclk_p2;
            cs_p0        <= spi_cs_n;
            cs_p1        <= cs_p0;
            cs_p2        <= cs_p1;
            cs_rise_p3   <= cs_p1 & ~cs_p2;
            mosi_p0      <= spi_mosi;
            mosi_p1      <= mosi_p0;
            mosi_p2      <= mosi_p1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (load_start) state_nx = ARMED;
            ARMED: if (!cs_p1) state_nx = SHIFT;
            SHIFT: begin
                if (cs_rise_p3)
                    state_nx = DONE;
                else if (sclk_rise_p3 && bit_cnt == BIT_LAST)
                    state_nx = WRITE;
            end
            // A chip-select release seen during the write still lets the word land first.
            WRITE: state_nx = (word_cnt == WORD_LAST || cs_p1) ? DONE : SHIFT;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign wrenb = (state == WRITE);
    assign csen  = (state == WRITE);
    assign done  = (state == DONE);
    assign busy  = (state == ARMED) || (state == SHIFT) || (state == WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            addr      <= '0;
            addr_b    <= '0;
            data_b    <= '0;
            word_cnt  <= '0;
            overflow  <= 1'b0;
            full      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        addr     <= '0;
                        word_cnt <= '0;
                        overflow <= 1'b0;
                        full     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end else if (full && !cs_p1 && sclk_rise_p3) begin
                        overflow <= 1'b1;
                    end
                end
                ARMED: bit_cnt <= '0;
                SHIFT: begin
                    if (sclk_rise_p3 && !cs_rise_p3) begin
                        shift_reg <= {shift_reg[DATA_WIDTH-2:0], mosi_p2};
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                        // Present the completed word on port B for the write cycle.
                        if (bit_cnt == BIT_LAST) begin
                            data_b <= {shift_reg[DATA_WIDTH-2:0], mosi_p2};
                            addr_b <= addr;
                        end
                    end
                end
                WRITE: begin
                    addr     <= addr + ADDR_WIDTH'(1);
                    word_cnt <= word_cnt + (ADDR_WIDTH + 1)'(1);
                    bit_cnt  <= '0;
                    if (word_cnt == WORD_LAST) full <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    checksum <= checksum + data_b;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bank_spi_loader.sv
// Directed self-checking bench for bank_spi_loader; SPI driven at clk/4 with mode-0 timing.
`timescale 1ns/1ps
module tb_bank_spi_loader;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_start = 1'b0;
    logic spi_sclk = 1'b0;
    logic spi_cs_n = 1'b1;
    logic spi_mosi = 1'b0;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] data_b;
    logic wrenb, csen, busy, done, overflow;
    logic [AW:0] word_cnt;
`ifdef LOADER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    int errors = 0;
    int checks = 0;
    longint cyc = 0;
    int wa[$];
    int wd[$];
    longint wc[$];
    longint lsb_cyc[$];
    int done_cnt = 0;
    int csen_bad = 0;

    bank_spi_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .addr_b(addr_b), .data_b(data_b), .wrenb(wrenb), .csen(csen),
        .busy(busy), .done(done), .overflow(overflow), .word_cnt(word_cnt)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wrenb === 1'b1) begin
            wa.push_back(int'(addr_b));
            wd.push_back(int'(data_b));
            wc.push_back(cyc);
        end
        if (done === 1'b1) done_cnt++;
        if (csen !== wrenb) csen_bad++;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        wa.delete(); wd.delete(); wc.delete(); lsb_cyc.delete();
        done_cnt = 0;
        csen_bad = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #2;
        load_start = 1'b1;
        @(posedge clk); #2;
        load_start = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            clks(2);
            spi_sclk = 1'b1;
            if (i == 0) lsb_cyc.push_back(cyc);
            clks(2);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clks(3);
        checks++; if ({wrenb, csen, busy, done, overflow} !== 5'b0) begin errors++;
            $display("FAIL reset_ctrl got=%b want=00000", {wrenb, csen, busy, done, overflow}); end
        checks++; if (addr_b !== '0 || data_b !== '0) begin errors++;
            $display("FAIL reset_data addr_b=%0d data_b=%0h want 0/0", addr_b, data_b); end
        checks++; if (word_cnt !== '0) begin errors++;
            $display("FAIL reset_word_cnt got=%0d want=0", word_cnt); end
        rst_n = 1'b1;
        clks(4);
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_full_overflow();
        int bad;
        clear_mon();
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++;
            $display("FAIL busy_after_start got=%b want=1", busy); end
        spi_cs_n = 1'b0;
        clks(4);
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i));
        clks(8);
        checks++; if (wa.size() != DEPTH) begin errors++;
            $display("FAIL full_count got=%0d want=%0d", wa.size(), DEPTH); end
        bad = 0;
        for (int i = 0; i < wa.size(); i++) if (wa[i] != i || wd[i] != (i & 255)) bad++;
        checks++; if (bad != 0) begin errors++;
            $display("FAIL full_seq bad_entries=%0d want=0", bad); end
        checks++; if (done_cnt != 1) begin errors++;
            $display("FAIL full_done got=%0d want=1", done_cnt); end
        checks++; if (word_cnt !== 14'(DEPTH)) begin errors++;
            $display("FAIL full_word_cnt got=%0d want=%0d", word_cnt, DEPTH); end
        checks++; if (overflow !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL full_flags overflow=%b busy=%b want 0/0", overflow, busy); end
        checks++; if (csen_bad != 0) begin errors++;
            $display("FAIL csen_tracks_wrenb bad_cycles=%0d want=0", csen_bad); end
`ifdef LOADER_CHECKSUM_EN
        checks++; if (checksum !== 8'h00) begin errors++;
            $display("FAIL full_checksum got=%0h want=00", checksum); end
`endif
        send_byte(8'h77);
        clks(8);
        checks++; if (wa.size() != DEPTH) begin errors++;
            $display("FAIL overflow_nowrite writes=%0d want=%0d", wa.size(), DEPTH); end
        checks++; if (overflow !== 1'b1) begin errors++;
            $display("FAIL overflow_set got=%b want=1", overflow); end
        spi_cs_n = 1'b1;
        clks(6);
        pulse_start();
        checks++; if (overflow !== 1'b0 || word_cnt !== '0) begin errors++;
            $display("FAIL overflow_clear overflow=%b word_cnt=%0d want 0/0", overflow, word_cnt); end
        spi_cs_n = 1'b0;
        clks(6);
        spi_cs_n = 1'b1;
        clks(10);
    endtask

    task automatic test_short();
        logic [7:0] exp [3];
        exp[0] = 8'hA5; exp[1] = 8'h3C; exp[2] = 8'hFF;
        clear_mon();
        pulse_start();
        spi_cs_n = 1'b0;
        clks(4);
        for (int i = 0; i < 3; i++) send_byte(exp[i]);
        send_bits(8'hD8, 5);
        clks(6);
        spi_cs_n = 1'b1;
        clks(10);
        checks++; if (wa.size() != 3) begin errors++;
            $display("FAIL short_count got=%0d want=3", wa.size()); end
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            checks++; if (wa[i] != i || wd[i] != int'(exp[i])) begin errors++;
                $display("FAIL short_word%0d got=%0d:%0h want=%0d:%0h", i, wa[i], wd[i], i, exp[i]); end
        end
        checks++; if (done_cnt != 1 || busy !== 1'b0) begin errors++;
            $display("FAIL short_done done_cnt=%0d busy=%b want 1/0", done_cnt, busy); end
        checks++; if (word_cnt !== 14'd3) begin errors++;
            $display("FAIL short_word_cnt got=%0d want=3", word_cnt); end
`ifdef LOADER_CHECKSUM_EN
        checks++; if (checksum !== 8'hE0) begin errors++;
            $display("FAIL short_checksum got=%0h want=e0", checksum); end
`endif
    endtask

    task automatic test_ignored_start();
        int bad;
        clear_mon();
        pulse_start();
        spi_cs_n = 1'b0;
        clks(4);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) pulse_start();
            send_byte(8'(8'h80 + i));
        end
        clks(6);
        spi_cs_n = 1'b1;
        clks(10);
        checks++; if (wa.size() != 20) begin errors++;
            $display("FAIL ign_count got=%0d want=20", wa.size()); end
        bad = 0;
        for (int i = 0; i < wa.size(); i++) if (wa[i] != i || wd[i] != 8'h80 + i) bad++;
        checks++; if (bad != 0) begin errors++;
            $display("FAIL ign_seq bad_entries=%0d want=0", bad); end
        checks++; if (word_cnt !== 14'd20 || done_cnt != 1) begin errors++;
            $display("FAIL ign_end word_cnt=%0d done_cnt=%0d want 20/1", word_cnt, done_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        pulse_start();
        spi_cs_n = 1'b0;
        clks(4);
        for (int i = 1; i <= 5; i++) send_byte(8'(8'h11 * i));
        clks(6);
        checks++; if (wa.size() != 5) begin errors++;
            $display("FAIL rmid_pre_count got=%0d want=5", wa.size()); end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++; if ({wrenb, csen, busy, done, overflow} !== 5'b0 || word_cnt !== '0
                      || addr_b !== '0 || data_b !== '0) begin errors++;
            $display("FAIL rmid_outputs ctrl=%b word_cnt=%0d addr_b=%0d data_b=%0h want all 0",
                     {wrenb, csen, busy, done, overflow}, word_cnt, addr_b, data_b); end
        clks(2);
        rst_n = 1'b1;
        clear_mon();
        send_byte(8'h5A);
        clks(8);
        checks++; if (wa.size() != 0 || overflow !== 1'b0) begin errors++;
            $display("FAIL rmid_quiet writes=%0d overflow=%b want 0/0", wa.size(), overflow); end
        spi_cs_n = 1'b1;
        clks(6);
        pulse_start();
        spi_cs_n = 1'b0;
        clks(4);
        send_byte(8'hC3);
        clks(6);
        spi_cs_n = 1'b1;
        clks(10);
        checks++; if (wa.size() != 1 || wa[0] != 0 || wd[0] != 8'hC3) begin errors++;
            $display("FAIL rmid_restart writes=%0d first=%0d:%0h want 1 at 0:c3",
                     wa.size(), (wa.size() > 0) ? wa[0] : -1, (wd.size() > 0) ? wd[0] : -1); end
        checks++; if (word_cnt !== 14'd1) begin errors++;
            $display("FAIL rmid_word_cnt got=%0d want=1", word_cnt); end
    endtask

    task automatic test_clock_ratio();
        logic [7:0] pat [4];
        longint lat;
        pat[0] = 8'h55; pat[1] = 8'hAA; pat[2] = 8'h55; pat[3] = 8'hAA;
        clear_mon();
        pulse_start();
        spi_cs_n = 1'b0;
        clks(4);
        for (int i = 0; i < 4; i++) send_byte(pat[i]);
        clks(6);
        spi_cs_n = 1'b1;
        clks(10);
        checks++; if (wa.size() != 4) begin errors++;
            $display("FAIL ratio_count got=%0d want=4", wa.size()); end
        for (int i = 0; i < 4 && i < wa.size() && i < lsb_cyc.size(); i++) begin
            lat = wc[i] - lsb_cyc[i];
            checks++; if (wd[i] != int'(pat[i]) || wa[i] != i) begin errors++;
                $display("FAIL ratio_word%0d got=%0d:%0h want=%0d:%0h", i, wa[i], wd[i], i, pat[i]); end
            checks++; if (lat < 4 || lat > 5) begin errors++;
                $display("FAIL ratio_latency%0d got=%0d want 4..5", i, lat); end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_full_overflow();
        test_short();
        test_ignored_start();
        test_reset_mid();
        test_clock_ratio();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
